apb_regfile_slave: RTL and testbench
====================================

APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001: Parameter BASE_ADDR, default 32'h0000_0000, is the 64-byte-aligned base of the register window.
REQ-002: Parameter WAIT_CYCLES, default 0, range 0..15, sets the wait states inserted before pready.
REQ-003: Parameter ID_VALUE, default 32'hA9B0_0001, is the constant returned by register 14.
REQ-004: pclk  input  1  sole clock; all state updates on its rising edge.
REQ-005: preset  input  1  reset, asynchronous, active-low.
REQ-006: psel  input  1  completer select.
REQ-007: penable  input  1  access-phase indicator.
REQ-008: paddr  input  32  byte address.
REQ-009: pwrite  input  1  1 = write, 0 = read.
REQ-010: pprot  input  3  protection; bit 1 = 1 means non-secure.
REQ-011: pwdata  input  32  write data.
REQ-012: pstrb  input  4  write byte strobes; bit n enables pwdata[8n+7:8n].
REQ-013: prdata  output  32  read data, valid only while pready=1.
REQ-014: pready  output  1  transfer completion.
REQ-015: pslverr  output  1  transfer error, valid only while pready=1.

Function
REQ-016: The block SHALL implement an FSM with states IDLE, ACCESS and DONE.
REQ-017: IDLE->ACCESS when psel=1 and penable=0 (setup phase); the wait counter SHALL load WAIT_CYCLES on this transition.
REQ-018: In ACCESS with psel=1 and penable=1, the counter SHALL decrement each cycle while nonzero.
REQ-019: pready SHALL be 1 only when the state is ACCESS, the counter is 0, psel=1 and penable=1; access-to-pready latency is therefore WAIT_CYCLES cycles (0 = first access cycle).
REQ-020: ACCESS->DONE on the edge at which pready=1; DONE->ACCESS (counter reloaded) if psel=1 and penable=0 (back-to-back setup); otherwise DONE->IDLE.
REQ-021: If psel drops while in ACCESS, the block SHALL return to IDLE with no register update and no counter increment.
REQ-022: Decode: the transfer is in range when paddr[31:6]==BASE_ADDR[31:6]; index = paddr[5:2].
REQ-023: pslverr SHALL be 1 with pready for any of these cases: out of range; paddr[1:0]!=0; a write to index 14 or 15; any access to index 0..3 with pprot[1]=1.
REQ-024: Registers 0..13 are 32-bit read/write; a non-error write SHALL update only the bytes whose pstrb bit is set, on the pready edge; pstrb=0 SHALL write nothing and still complete without error.
REQ-025: Register 14 SHALL read ID_VALUE.
REQ-026: Register 15 SHALL be a 32-bit count of completed non-error transfers, incremented on the pready edge and wrapping from FFFF_FFFF to 0.
REQ-027: prdata SHALL be the indexed register on a non-error read with pready=1, and 0 otherwise (including on errored transfers and on writes).
REQ-028: An errored write SHALL leave all registers unchanged.
REQ-029: pstrb SHALL be ignored on reads.
REQ-030: A read of register 15 in the same transfer that increments it SHALL return the pre-increment value.

Reset
REQ-031: When preset=0, the block SHALL asynchronously enter IDLE, clear the wait counter, clear registers 0..13 and 15 to 0, and drive pready=0, pslverr=0 and prdata=0.
REQ-032: A reset asserted mid-transfer SHALL abort the transfer with no write committed.
REQ-033: The first transfer accepted after preset deasserts SHALL start from IDLE.

Structure
REQ-034: A shared package apb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), the register-index constants (ID_IDX=14, CNT_IDX=15, SECURE_MAX_IDX=3) and the PPROT_NS bit position.
REQ-035: Byte-strobe merging SHALL live in one sub-module, apb_strb_merge (old word, new word, pstrb -> merged word).

Verification
REQ-036: WAIT_CYCLES=0: write 32'hDEAD_BEEF to BASE+0x10 with pstrb=4'hF, then read it back -> pready in the first access cycle, prdata=DEAD_BEEF, pslverr=0.
REQ-037: WAIT_CYCLES=3: read BASE+0x38 -> pready after exactly 3 wait cycles, prdata=ID_VALUE.
REQ-038: Register 5 holds 0; write 32'h1122_3344 with pstrb=4'b0101 -> register 5 reads 32'h0022_0044.
REQ-039: Error cases -> pslverr=1, prdata=0, no state change: write to index 15; read with paddr=BASE+0x41; access to index 2 with pprot=3'b010.
REQ-040: Issue 3 good transfers and 1 errored transfer, then read register 15 -> returns 3; drop psel mid-ACCESS -> FSM in IDLE, count unchanged.
REQ-041: Assert preset during the wait states of a write to index 7 -> register 7 reads 0 after reset and pready never rises for the aborted transfer.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB register-file definitions: FSM state encoding, special register
// indices and the pprot bit that marks a non-secure access.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_state_e;

  localparam int unsigned ID_IDX         = 14;
  localparam int unsigned CNT_IDX        = 15;
  localparam int unsigned SECURE_MAX_IDX = 3;
  localparam int unsigned PPROT_NS       = 1;

endpackage

// File: rtl/apb_strb_merge.sv
// Byte-lane merge: each set strobe bit takes that byte from the new word,
// every other byte keeps the old value.
module apb_strb_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  strb_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb_i[b]) merged_o[8*b +: 8] = new_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer with 14 R/W registers, an ID register and a completed-transfer
// counter, programmable wait states and pprot-based secure window.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [2:0]  pprot,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  apb_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] regs_q [14];
  logic [31:0] xfer_cnt_q;

  logic [3:0]  idx;
  logic        err;
  logic [31:0] old_word, merged_word, rd_val;
  logic        unused_prot;

  assign unused_prot = ^{pprot[2], pprot[0]};
  assign idx = paddr[5:2];

  assign err = (paddr[31:6] != BASE_ADDR[31:6])
            || (paddr[1:0] != 2'b00)
            || (pwrite && (idx >= 4'(ID_IDX)))
            || (pprot[PPROT_NS] && (idx <= 4'(SECURE_MAX_IDX)));

  assign pready  = (state_q == ACCESS) && (cnt_q == 4'd0) && psel && penable;
  assign pslverr = pready && err;
  assign prdata  = (pready && !err && !pwrite) ? rd_val : '0;

  always_comb begin
    old_word = '0;
    for (int unsigned i = 0; i < 14; i++) begin
      if (idx == 4'(i)) old_word = regs_q[i];
    end
  end

  always_comb begin
    rd_val = old_word;
    if (idx == 4'(ID_IDX))  rd_val = ID_VALUE;
    if (idx == 4'(CNT_IDX)) rd_val = xfer_cnt_q;
  end

  apb_strb_merge u_merge (
    .old_i    (old_word),
    .new_i    (pwdata),
    .strb_i   (pstrb),
    .merged_o (merged_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q == 4'd0) state_d = DONE;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Commit happens only on the pready edge; reads of the counter see the
  // pre-increment value because prdata is combinational from xfer_cnt_q.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      for (int unsigned i = 0; i < 14; i++) regs_q[i] <= '0;
      xfer_cnt_q <= '0;
    end else if (pready && !err) begin
      xfer_cnt_q <= xfer_cnt_q + 32'd1;
      if (pwrite) begin
        for (int unsigned i = 0; i < 14; i++) begin
          if (idx == 4'(i)) regs_q[i] <= merged_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Two completers (0 and 3 wait states, different bases) driven by directed
// and random APB transfers, checked against a register-file model.
module tb_apb_regfile_slave;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h4000_1000;
  localparam logic [31:0] ID0   = 32'hA9B0_0001;
  localparam logic [31:0] ID1   = 32'h1234_5678;

  logic        pclk = 1'b0;
  logic        preset  [2];
  logic        psel    [2];
  logic        penable [2];
  logic [31:0] paddr   [2];
  logic        pwrite  [2];
  logic [2:0]  pprot   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [2][14];
  logic [31:0] m_cnt  [2];
  logic [31:0] m_base [2];
  logic [31:0] m_id   [2];
  int          m_wait [2];

  always #5 pclk = ~pclk;

  apb_regfile_slave #(.BASE_ADDR(BASE0), .WAIT_CYCLES(0), .ID_VALUE(ID0)) dut0 (
    .pclk(pclk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]),
    .paddr(paddr[0]), .pwrite(pwrite[0]), .pprot(pprot[0]), .pwdata(pwdata[0]),
    .pstrb(pstrb[0]), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb_regfile_slave #(.BASE_ADDR(BASE1), .WAIT_CYCLES(3), .ID_VALUE(ID1)) dut1 (
    .pclk(pclk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]),
    .paddr(paddr[1]), .pwrite(pwrite[1]), .pprot(pprot[1]), .pwdata(pwdata[1]),
    .pstrb(pstrb[1]), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 14; i++) m_regs[d][i] = '0;
    m_cnt[d] = '0;
  endtask

  task automatic bus_idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0; paddr[d] = '0; pwrite[d] = 1'b0;
    pprot[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
  endtask

  // One full APB transfer; expected response comes from the model, which is
  // then updated with the transfer's effect.
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [3:0] st,
                      input logic [2:0] pr, output logic [31:0] rd);
    int          idx, waits;
    logic        e_err;
    logic [31:0] e_rd;
    idx   = int'(addr[5:2]);
    e_err = (addr[31:6] != m_base[d][31:6]) || (addr[1:0] != 2'b00) ||
            (wr && idx >= 14) || (pr[1] && idx <= 3);
    if (e_err || wr)  e_rd = '0;
    else if (idx == 14) e_rd = m_id[d];
    else if (idx == 15) e_rd = m_cnt[d];
    else              e_rd = m_regs[d][idx];

    @(negedge pclk);
    psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = addr; pwrite[d] = wr;
    pwdata[d] = wd; pstrb[d] = st; pprot[d] = pr;
    @(negedge pclk);
    penable[d] = 1'b1;
    #1;
    waits = 0;
    while (pready[d] !== 1'b1 && waits < 40) begin
      @(negedge pclk);
      #1;
      waits++;
    end
    rd = prdata[d];
    if (waits >= 40) begin
      chk($sformatf("d%0d pready_timeout", d), {31'd0, pready[d]}, 32'd1);
    end else begin
      chk($sformatf("d%0d latency a=%h", d, addr), waits, m_wait[d]);
      chk($sformatf("d%0d pslverr a=%h", d, addr), {31'd0, pslverr[d]}, {31'd0, e_err});
      chk($sformatf("d%0d prdata a=%h", d, addr), prdata[d], e_rd);
      if (!e_err) begin
        if (wr && idx < 14)
          for (int b = 0; b < 4; b++)
            if (st[b]) m_regs[d][idx][8*b +: 8] = wd[8*b +: 8];
        m_cnt[d] = m_cnt[d] + 1;
      end
    end
    @(negedge pclk);
    bus_idle(d);
  endtask

  initial begin
    logic [31:0] rd, a;
    int r;
    m_base[0] = BASE0; m_base[1] = BASE1;
    m_id[0]   = ID0;   m_id[1]   = ID1;
    m_wait[0] = 0;     m_wait[1] = 3;
    for (int d = 0; d < 2; d++) begin
      preset[d] = 1'b0; bus_idle(d); model_reset(d);
    end
    repeat (2) @(negedge pclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset pready", d),  {31'd0, pready[d]}, 32'd0);
      chk($sformatf("d%0d reset pslverr", d), {31'd0, pslverr[d]}, 32'd0);
      chk($sformatf("d%0d reset prdata", d),  prdata[d], 32'd0);
    end
    @(negedge pclk);
    preset[0] = 1'b1; preset[1] = 1'b1;

    // zero-wait write/readback and partial strobes
    xfer(0, BASE0 + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000, rd);
    xfer(0, BASE0 + 32'h10, 1'b0, '0, 4'h0, 3'b000, rd);
    chk("readback DEADBEEF", rd, 32'hDEAD_BEEF);
    xfer(0, BASE0 + 32'h14, 1'b1, 32'h1122_3344, 4'b0101, 3'b000, rd);
    xfer(0, BASE0 + 32'h14, 1'b0, '0, 4'hA, 3'b000, rd);
    chk("reg5 strobe merge", rd, 32'h0022_0044);
    xfer(0, BASE0 + 32'h14, 1'b1, 32'hFFFF_FFFF, 4'b0000, 3'b000, rd);
    xfer(0, BASE0 + 32'h14, 1'b0, '0, 4'h0, 3'b000, rd);
    chk("reg5 after pstrb=0", rd, 32'h0022_0044);

    // error cases leave state alone
    xfer(0, BASE0 + 32'h3C, 1'b1, 32'h5555_5555, 4'hF, 3'b000, rd);
    xfer(0, BASE0 + 32'h41, 1'b0, '0, 4'h0, 3'b000, rd);
    xfer(0, BASE0 + 32'h08, 1'b1, 32'h0BAD_0BAD, 4'hF, 3'b010, rd);
    xfer(0, BASE0 + 32'h08, 1'b0, '0, 4'h0, 3'b010, rd);
    xfer(0, BASE0 + 32'h08, 1'b0, '0, 4'h0, 3'b000, rd);
    chk("reg2 untouched by errored write", rd, 32'd0);
    xfer(0, BASE0 + 32'h3C, 1'b0, '0, 4'h0, 3'b000, rd);

    // three wait states, ID register
    xfer(1, BASE1 + 32'h38, 1'b0, '0, 4'h0, 3'b000, rd);
    chk("ID with 3 waits", rd, ID1);

    // psel dropped mid-access: no pready, no count
    @(negedge pclk);
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = BASE1 + 32'h20; pwrite[1] = 1'b1;
    pwdata[1] = 32'hCAFE_F00D; pstrb[1] = 4'hF;
    @(negedge pclk);
    penable[1] = 1'b1;
    #1 chk("drop psel access pready", {31'd0, pready[1]}, 32'd0);
    @(negedge pclk);
    bus_idle(1);
    @(negedge pclk);
    #1 chk("drop psel after pready", {31'd0, pready[1]}, 32'd0);
    xfer(1, BASE1 + 32'h20, 1'b0, '0, 4'h0, 3'b000, rd);
    chk("drop psel no write", rd, 32'd0);

    // reset during wait states of a write to index 7
    @(negedge pclk);
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = BASE1 + 32'h1C; pwrite[1] = 1'b1;
    pwdata[1] = 32'h7777_7777; pstrb[1] = 4'hF;
    @(negedge pclk);
    penable[1] = 1'b1;
    @(negedge pclk);
    preset[1] = 1'b0;
    model_reset(1);
    for (int k = 0; k < 4; k++) begin
      #1 chk("abort pready", {31'd0, pready[1]}, 32'd0);
      @(negedge pclk);
    end
    bus_idle(1);
    @(negedge pclk);
    preset[1] = 1'b1;
    xfer(1, BASE1 + 32'h1C, 1'b0, '0, 4'h0, 3'b000, rd);
    chk("reg7 after abort", rd, 32'd0);

    // completed-transfer counter: reg7 read above + 2 good + 1 errored
    xfer(1, BASE1 + 32'h00, 1'b1, 32'h0102_0304, 4'hF, 3'b000, rd);
    xfer(1, BASE1 + 32'h00, 1'b0, '0, 4'h0, 3'b000, rd);
    xfer(1, BASE1 + 32'h3C, 1'b1, 32'h0, 4'hF, 3'b000, rd);
    xfer(1, BASE1 + 32'h3C, 1'b0, '0, 4'h0, 3'b000, rd);
    chk("transfer count", rd, 32'd3);

    // random traffic on both completers
    for (int n = 0; n < 120; n++) begin
      int d;
      d = n % 2;
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else begin
        a = m_base[d] | (32'($urandom_range(0, 15)) << 2);
        if (r == 1) a[1:0] = 2'($urandom_range(0, 3));
      end
      xfer(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), rd);
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 14; i++)
        xfer(d, m_base[d] + 32'(i * 4), 1'b0, '0, 4'h0, 3'b000, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
